// File: rtl/core_sequencer_if.sv
// ----------------------------------------------------------------------------
// core_sequencer_if
//   Instruction- and data-memory handshake bundle between the core sequencer
//   and the memory system.
//
//   imem_req    sequencer -> imem : instruction fetch request
//   imem_ready  imem -> sequencer : instruction word valid this cycle
//   dmem_req    sequencer -> dmem : data access request
//   dmem_we     sequencer -> dmem : 1 = store, 0 = load
//   dmem_ready  dmem -> sequencer : data access complete
// ----------------------------------------------------------------------------
interface core_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        input  imem_ready,
        output dmem_req,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        output imem_ready,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready
    );
endinterface

// File: rtl/core_sequencer.sv
// ----------------------------------------------------------------------------
// core_sequencer
//   Multi-cycle control FSM for the RV32I core. Walks one instruction at a
//   time through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and diverts to
//   TRAP on illegal instructions or memory timeouts, or to HALT on SYSTEM.
//
//   Parameters
//     TIMEOUT   max cycles waiting for a ready before trapping (0 = never)
//     CNT_W     wait-counter width, 2**CNT_W > TIMEOUT
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     mem                   memory handshake bundle (master side)
//     inst_load             latch fetched word into the instruction register
//     dec_nreset            decoder enable; 0 blanks the decoder outputs
//     is_* / mem_en / rw /  decoder class flags
//     rd_enc
//     branch_taken          ALU compare result
//     rf_we, pc_we, pc_sel  register-file and PC update controls
//     trap, trap_cause      one-cycle trap pulse and sticky cause
//     halted                core stopped on a SYSTEM instruction
//     instret               retired-instruction counter
//     state_dbg             current state encoding
// ----------------------------------------------------------------------------
module core_sequencer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    core_sequencer_if.master       mem,
    output logic                   inst_load,
    output logic                   dec_nreset,
    input  logic                   is_invalid,
    input  logic                   is_jal,
    input  logic                   is_jalr,
    input  logic                   is_branch,
    input  logic                   is_fence,
    input  logic                   is_system,
    input  logic                   mem_en,
    input  logic                   rw,
    input  logic                   rd_enc,
    input  logic                   branch_taken,
    output logic                   rf_we,
    output logic                   pc_we,
    output logic [1:0]             pc_sel,
    output logic                   trap,
    output logic [1:0]             trap_cause,
    output logic                   halted,
    output logic [31:0]            instret,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_TRAP   = 2'b10;

    localparam logic [1:0] CAUSE_FETCH   = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_DATA    = 2'b11;

    // Counter value seen on the last permitted wait cycle; reaching it
    // without a ready means the TIMEOUT-th wait cycle has elapsed.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [31:0]      r_instret;
    logic [1:0]       r_trap_cause;

    logic             w_timeout_hit;
    logic             w_waiting;
    logic             w_retire;
    logic             w_set_cause;
    logic [1:0]       w_next_cause;

    logic             w_imem_req;
    logic             w_inst_load;
    logic             w_dec_nreset;
    logic             w_dmem_req;
    logic             w_dmem_we;
    logic             w_rf_we;
    logic             w_pc_we;
    logic [1:0]       w_pc_sel;
    logic             w_trap;
    logic             w_halted;

    assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == CNT_LAST);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_wait_cnt   <= '0;
            r_instret    <= '0;
            r_trap_cause <= '0;
        end else begin
            r_state <= w_next_state;
            // Counter only runs while stalled in FETCH/MEM, so it is always
            // zero on entry to either waiting state.
            if (w_waiting) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
            if (w_set_cause) begin
                r_trap_cause <= w_next_cause;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_waiting    = 1'b0;
        w_retire     = 1'b0;
        w_set_cause  = 1'b0;
        w_next_cause = r_trap_cause;
        w_imem_req   = 1'b0;
        w_inst_load  = 1'b0;
        w_dec_nreset = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_rf_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_sel     = PC_SEQ;
        w_trap       = 1'b0;
        w_halted     = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                // Ready takes priority over an expiring timeout.
                if (mem.imem_ready) begin
                    w_inst_load  = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout_hit) begin
                    w_next_state = S_TRAP;
                    w_set_cause  = 1'b1;
                    w_next_cause = CAUSE_FETCH;
                end else begin
                    w_waiting = 1'b1;
                end
            end

            S_DECODE: begin
                w_dec_nreset = 1'b1;
                if (is_invalid) begin
                    w_next_state = S_TRAP;
                    w_set_cause  = 1'b1;
                    w_next_cause = CAUSE_ILLEGAL;
                end else if (is_system) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                w_dec_nreset = 1'b1;
                // FENCE retires as a NOP and never touches data memory.
                if (mem_en && !is_fence) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_WRITEBACK;
                end
            end

            S_MEM: begin
                w_dec_nreset = 1'b1;
                w_dmem_req   = 1'b1;
                w_dmem_we    = rw;
                if (mem.dmem_ready) begin
                    w_next_state = S_WRITEBACK;
                end else if (w_timeout_hit) begin
                    w_next_state = S_TRAP;
                    w_set_cause  = 1'b1;
                    w_next_cause = CAUSE_DATA;
                end else begin
                    w_waiting = 1'b1;
                end
            end

            S_WRITEBACK: begin
                w_dec_nreset = 1'b1;
                w_rf_we      = rd_enc;
                w_pc_we      = 1'b1;
                if (is_jal || is_jalr || (is_branch && branch_taken)) begin
                    w_pc_sel = PC_TARGET;
                end
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end

            S_TRAP: begin
                w_trap       = 1'b1;
                w_pc_we      = 1'b1;
                w_pc_sel     = PC_TRAP;
                w_next_state = S_FETCH;
            end

            S_HALT: begin
                w_halted = 1'b1;
            end

            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // All outputs are held low for as long as reset is asserted, including
    // the cycle in which reset first arrives mid-transaction.
    assign mem.imem_req = w_imem_req   & ~reset;
    assign mem.dmem_req = w_dmem_req   & ~reset;
    assign mem.dmem_we  = w_dmem_we    & ~reset;
    assign inst_load    = w_inst_load  & ~reset;
    assign dec_nreset   = w_dec_nreset & ~reset;
    assign rf_we        = w_rf_we      & ~reset;
    assign pc_we        = w_pc_we      & ~reset;
    assign pc_sel       = w_pc_sel     & {2{~reset}};
    assign trap         = w_trap       & ~reset;
    assign halted       = w_halted     & ~reset;
    assign trap_cause   = r_trap_cause & {2{~reset}};
    assign instret      = r_instret    & {32{~reset}};
    assign state_dbg    = r_state      & {3{~reset}};

endmodule

// File: tb/tb_core_sequencer.sv
// ----------------------------------------------------------------------------
// tb_core_sequencer
//   Directed bench for core_sequencer (TIMEOUT = 4). Each scenario task walks
//   a hand-written per-cycle table of inputs and expected state/strobes.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
// ----------------------------------------------------------------------------
module tb_core_sequencer;

    localparam logic [2:0] ST_F = 3'd0;
    localparam logic [2:0] ST_D = 3'd1;
    localparam logic [2:0] ST_E = 3'd2;
    localparam logic [2:0] ST_M = 3'd3;
    localparam logic [2:0] ST_W = 3'd4;
    localparam logic [2:0] ST_T = 3'd5;
    localparam logic [2:0] ST_H = 3'd6;

    // Strobe vector:
    // {imem_req, inst_load, dec_nreset, dmem_req, dmem_we, rf_we, pc_we,
    //  pc_sel[1:0], trap, halted}
    localparam logic [10:0] SB_NONE      = 11'b00000000000;
    localparam logic [10:0] SB_F_RDY     = 11'b11000000000;
    localparam logic [10:0] SB_F_NORDY   = 11'b10000000000;
    localparam logic [10:0] SB_DEC       = 11'b00100000000;
    localparam logic [10:0] SB_MEM_RD    = 11'b00110000000;
    localparam logic [10:0] SB_MEM_WR    = 11'b00111000000;
    localparam logic [10:0] SB_WB_RD     = 11'b00100110000;
    localparam logic [10:0] SB_WB_NORD   = 11'b00100010000;
    localparam logic [10:0] SB_WB_NORD_J = 11'b00100010100;
    localparam logic [10:0] SB_WB_RD_J   = 11'b00100110100;
    localparam logic [10:0] SB_TRAP      = 11'b00000011010;
    localparam logic [10:0] SB_HALT      = 11'b00000000001;

    // Instruction flags:
    // {is_invalid, is_jal, is_jalr, is_branch, branch_taken, is_fence,
    //  is_system, mem_en, rw, rd_enc}
    localparam logic [9:0] I_ADD     = 10'b0000000001;
    localparam logic [9:0] I_LOAD    = 10'b0000000101;
    localparam logic [9:0] I_STORE   = 10'b0000000110;
    localparam logic [9:0] I_BEQ_T   = 10'b0001100000;
    localparam logic [9:0] I_BNE_NT  = 10'b0001000000;
    localparam logic [9:0] I_JAL     = 10'b0100000001;
    localparam logic [9:0] I_JALR    = 10'b0010000001;
    localparam logic [9:0] I_INVALID = 10'b1000000001;
    localparam logic [9:0] I_FENCE   = 10'b0000010000;
    localparam logic [9:0] I_ECALL   = 10'b0000001000;

    typedef struct packed {
        logic [9:0]  ins;
        logic        im;
        logic        dm;
        logic [2:0]  st;
        logic [10:0] sb;
    } row_t;

    logic        clk;
    logic        reset;
    logic        inst_load;
    logic        dec_nreset;
    logic        is_invalid;
    logic        is_jal;
    logic        is_jalr;
    logic        is_branch;
    logic        is_fence;
    logic        is_system;
    logic        mem_en;
    logic        rw;
    logic        rd_enc;
    logic        branch_taken;
    logic        rf_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        trap;
    logic [1:0]  trap_cause;
    logic        halted;
    logic [31:0] instret;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    core_sequencer_if mem_if ();

    core_sequencer #(
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem          (mem_if),
        .inst_load    (inst_load),
        .dec_nreset   (dec_nreset),
        .is_invalid   (is_invalid),
        .is_jal       (is_jal),
        .is_jalr      (is_jalr),
        .is_branch    (is_branch),
        .is_fence     (is_fence),
        .is_system    (is_system),
        .mem_en       (mem_en),
        .rw           (rw),
        .rd_enc       (rd_enc),
        .branch_taken (branch_taken),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .halted       (halted),
        .instret      (instret),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] strobes();
        return {mem_if.imem_req, inst_load, dec_nreset, mem_if.dmem_req,
                mem_if.dmem_we, rf_we, pc_we, pc_sel, trap, halted};
    endfunction

    task automatic set_instr(input logic [9:0] f);
        {is_invalid, is_jal, is_jalr, is_branch, branch_taken, is_fence,
         is_system, mem_en, rw, rd_enc} = f;
    endtask

    // Drive one cycle of ready inputs, sample on the falling edge, and
    // return just after the next rising edge.
    task automatic cycle(input logic im, input logic dm,
                         output logic [2:0] st, output logic [10:0] sb);
        mem_if.imem_ready = im;
        mem_if.dmem_ready = dm;
        @(negedge clk);
        st = state_dbg;
        sb = strobes();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_instr(I_JAL);
        mem_if.imem_ready = 1'b1;
        mem_if.dmem_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (strobes() !== SB_NONE || state_dbg !== ST_F || instret !== 32'd0 ||
            trap_cause !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_outputs: strobes=%b state=%0d instret=%0d cause=%b, expected all zero",
                     strobes(), state_dbg, instret, trap_cause);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (state_dbg !== ST_F) begin
            n_errors++;
            $display("FAIL reset_state: state=%0d, expected %0d", state_dbg, ST_F);
        end
    endtask

    task automatic test_add();
        logic [2:0]  st;
        logic [10:0] sb;
        row_t rows [4] = '{
            '{I_ADD, 1'b1, 1'b0, ST_F, SB_F_RDY},
            '{I_ADD, 1'b1, 1'b0, ST_D, SB_DEC},
            '{I_ADD, 1'b1, 1'b0, ST_E, SB_DEC},
            '{I_ADD, 1'b1, 1'b0, ST_W, SB_WB_RD}
        };
        for (int c = 0; c < 4; c++) begin
            set_instr(rows[c].ins);
            cycle(rows[c].im, rows[c].dm, st, sb);
            n_checks++;
            if (st !== rows[c].st || sb !== rows[c].sb) begin
                n_errors++;
                $display("FAIL add cycle %0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                         c + 1, st, sb, rows[c].st, rows[c].sb);
            end
        end
        n_checks++;
        if (instret !== 32'd1 || state_dbg !== ST_F) begin
            n_errors++;
            $display("FAIL add_retire: instret=%0d state=%0d, expected 1 and %0d",
                     instret, state_dbg, ST_F);
        end
    endtask

    task automatic test_load_wait();
        logic [2:0]  st;
        logic [10:0] sb;
        // dmem_ready high outside MEM must be ignored.
        row_t rows [8] = '{
            '{I_LOAD, 1'b1, 1'b1, ST_F, SB_F_RDY},
            '{I_LOAD, 1'b0, 1'b1, ST_D, SB_DEC},
            '{I_LOAD, 1'b0, 1'b1, ST_E, SB_DEC},
            '{I_LOAD, 1'b0, 1'b0, ST_M, SB_MEM_RD},
            '{I_LOAD, 1'b0, 1'b0, ST_M, SB_MEM_RD},
            '{I_LOAD, 1'b0, 1'b0, ST_M, SB_MEM_RD},
            '{I_LOAD, 1'b0, 1'b1, ST_M, SB_MEM_RD},
            '{I_LOAD, 1'b0, 1'b0, ST_W, SB_WB_RD}
        };
        for (int c = 0; c < 8; c++) begin
            set_instr(rows[c].ins);
            cycle(rows[c].im, rows[c].dm, st, sb);
            n_checks++;
            if (st !== rows[c].st || sb !== rows[c].sb) begin
                n_errors++;
                $display("FAIL load cycle %0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                         c + 1, st, sb, rows[c].st, rows[c].sb);
            end
        end
        n_checks++;
        if (instret !== 32'd2) begin
            n_errors++;
            $display("FAIL load_retire: instret=%0d, expected 2", instret);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  st;
        logic [10:0] sb;
        row_t rows [21] = '{
            '{I_STORE,  1'b1, 1'b0, ST_F, SB_F_RDY},
            '{I_STORE,  1'b0, 1'b0, ST_D, SB_DEC},
            '{I_STORE,  1'b0, 1'b0, ST_E, SB_DEC},
            '{I_STORE,  1'b0, 1'b1, ST_M, SB_MEM_WR},
            '{I_STORE,  1'b0, 1'b0, ST_W, SB_WB_NORD},
            '{I_BEQ_T,  1'b1, 1'b0, ST_F, SB_F_RDY},
            '{I_BEQ_T,  1'b0, 1'b1, ST_D, SB_DEC},
            '{I_BEQ_T,  1'b0, 1'b1, ST_E, SB_DEC},
            '{I_BEQ_T,  1'b0, 1'b0, ST_W, SB_WB_NORD_J},
            '{I_BNE_NT, 1'b1, 1'b0, ST_F, SB_F_RDY},
            '{I_BNE_NT, 1'b0, 1'b0, ST_D, SB_DEC},
            '{I_BNE_NT, 1'b0, 1'b0, ST_E, SB_DEC},
            '{I_BNE_NT, 1'b0, 1'b0, ST_W, SB_WB_NORD},
            '{I_JAL,    1'b1, 1'b0, ST_F, SB_F_RDY},
            '{I_JAL,    1'b0, 1'b0, ST_D, SB_DEC},
            '{I_JAL,    1'b0, 1'b0, ST_E, SB_DEC},
            '{I_JAL,    1'b0, 1'b0, ST_W, SB_WB_RD_J},
            '{I_JALR,   1'b1, 1'b0, ST_F, SB_F_RDY},
            '{I_JALR,   1'b0, 1'b0, ST_D, SB_DEC},
            '{I_JALR,   1'b0, 1'b0, ST_E, SB_DEC},
            '{I_JALR,   1'b0, 1'b0, ST_W, SB_WB_RD_J}
        };
        for (int c = 0; c < 21; c++) begin
            set_instr(rows[c].ins);
            cycle(rows[c].im, rows[c].dm, st, sb);
            n_checks++;
            if (st !== rows[c].st || sb !== rows[c].sb) begin
                n_errors++;
                $display("FAIL back_to_back cycle %0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                         c + 1, st, sb, rows[c].st, rows[c].sb);
            end
        end
        n_checks++;
        if (instret !== 32'd7) begin
            n_errors++;
            $display("FAIL back_to_back_retire: instret=%0d, expected 7", instret);
        end
    endtask

    task automatic test_illegal();
        logic [2:0]  st;
        logic [10:0] sb;
        row_t rows [3] = '{
            '{I_INVALID, 1'b1, 1'b0, ST_F, SB_F_RDY},
            '{I_INVALID, 1'b0, 1'b0, ST_D, SB_DEC},
            '{I_INVALID, 1'b1, 1'b1, ST_T, SB_TRAP}
        };
        for (int c = 0; c < 3; c++) begin
            set_instr(rows[c].ins);
            cycle(rows[c].im, rows[c].dm, st, sb);
            n_checks++;
            if (st !== rows[c].st || sb !== rows[c].sb) begin
                n_errors++;
                $display("FAIL illegal cycle %0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                         c + 1, st, sb, rows[c].st, rows[c].sb);
            end
        end
        n_checks++;
        if (trap_cause !== 2'b10 || instret !== 32'd7 || state_dbg !== ST_F) begin
            n_errors++;
            $display("FAIL illegal_after: cause=%b instret=%0d state=%0d, expected 10, 7, %0d",
                     trap_cause, instret, state_dbg, ST_F);
        end
    endtask

    task automatic test_fetch_timeout();
        logic [2:0]  st;
        logic [10:0] sb;
        row_t to_rows [5] = '{
            '{I_FENCE, 1'b0, 1'b1, ST_F, SB_F_NORDY},
            '{I_FENCE, 1'b0, 1'b1, ST_F, SB_F_NORDY},
            '{I_FENCE, 1'b0, 1'b1, ST_F, SB_F_NORDY},
            '{I_FENCE, 1'b0, 1'b1, ST_F, SB_F_NORDY},
            '{I_FENCE, 1'b0, 1'b0, ST_T, SB_TRAP}
        };
        // Ready on the last permitted wait cycle wins over the timeout;
        // the FENCE then retires as a NOP.
        row_t ok_rows [7] = '{
            '{I_FENCE, 1'b0, 1'b0, ST_F, SB_F_NORDY},
            '{I_FENCE, 1'b0, 1'b0, ST_F, SB_F_NORDY},
            '{I_FENCE, 1'b0, 1'b0, ST_F, SB_F_NORDY},
            '{I_FENCE, 1'b1, 1'b0, ST_F, SB_F_RDY},
            '{I_FENCE, 1'b0, 1'b0, ST_D, SB_DEC},
            '{I_FENCE, 1'b0, 1'b0, ST_E, SB_DEC},
            '{I_FENCE, 1'b0, 1'b0, ST_W, SB_WB_NORD}
        };
        for (int c = 0; c < 5; c++) begin
            set_instr(to_rows[c].ins);
            cycle(to_rows[c].im, to_rows[c].dm, st, sb);
            n_checks++;
            if (st !== to_rows[c].st || sb !== to_rows[c].sb) begin
                n_errors++;
                $display("FAIL fetch_timeout cycle %0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                         c + 1, st, sb, to_rows[c].st, to_rows[c].sb);
            end
        end
        n_checks++;
        if (trap_cause !== 2'b01 || instret !== 32'd7) begin
            n_errors++;
            $display("FAIL fetch_timeout_cause: cause=%b instret=%0d, expected 01 and 7",
                     trap_cause, instret);
        end
        for (int c = 0; c < 7; c++) begin
            set_instr(ok_rows[c].ins);
            cycle(ok_rows[c].im, ok_rows[c].dm, st, sb);
            n_checks++;
            if (st !== ok_rows[c].st || sb !== ok_rows[c].sb) begin
                n_errors++;
                $display("FAIL fetch_ready_late cycle %0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                         c + 1, st, sb, ok_rows[c].st, ok_rows[c].sb);
            end
        end
        n_checks++;
        if (trap_cause !== 2'b01 || instret !== 32'd8) begin
            n_errors++;
            $display("FAIL fetch_ready_late_after: cause=%b instret=%0d, expected 01 and 8",
                     trap_cause, instret);
        end
    endtask

    task automatic test_data_timeout();
        logic [2:0]  st;
        logic [10:0] sb;
        row_t rows [8] = '{
            '{I_LOAD, 1'b1, 1'b0, ST_F, SB_F_RDY},
            '{I_LOAD, 1'b0, 1'b0, ST_D, SB_DEC},
            '{I_LOAD, 1'b0, 1'b0, ST_E, SB_DEC},
            '{I_LOAD, 1'b1, 1'b0, ST_M, SB_MEM_RD},
            '{I_LOAD, 1'b1, 1'b0, ST_M, SB_MEM_RD},
            '{I_LOAD, 1'b1, 1'b0, ST_M, SB_MEM_RD},
            '{I_LOAD, 1'b1, 1'b0, ST_M, SB_MEM_RD},
            '{I_LOAD, 1'b0, 1'b1, ST_T, SB_TRAP}
        };
        for (int c = 0; c < 8; c++) begin
            set_instr(rows[c].ins);
            cycle(rows[c].im, rows[c].dm, st, sb);
            n_checks++;
            if (st !== rows[c].st || sb !== rows[c].sb) begin
                n_errors++;
                $display("FAIL data_timeout cycle %0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                         c + 1, st, sb, rows[c].st, rows[c].sb);
            end
        end
        n_checks++;
        if (trap_cause !== 2'b11 || instret !== 32'd8 || state_dbg !== ST_F) begin
            n_errors++;
            $display("FAIL data_timeout_after: cause=%b instret=%0d state=%0d, expected 11, 8, %0d",
                     trap_cause, instret, state_dbg, ST_F);
        end
    endtask

    task automatic test_halt();
        logic [2:0]  st;
        logic [10:0] sb;
        row_t rows [2] = '{
            '{I_ECALL, 1'b1, 1'b0, ST_F, SB_F_RDY},
            '{I_ECALL, 1'b0, 1'b0, ST_D, SB_DEC}
        };
        for (int c = 0; c < 2; c++) begin
            set_instr(rows[c].ins);
            cycle(rows[c].im, rows[c].dm, st, sb);
            n_checks++;
            if (st !== rows[c].st || sb !== rows[c].sb) begin
                n_errors++;
                $display("FAIL halt_entry cycle %0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                         c + 1, st, sb, rows[c].st, rows[c].sb);
            end
        end
        // Stays halted with no strobes even with both readies pulled high.
        for (int c = 0; c < 20; c++) begin
            cycle(1'b1, 1'b1, st, sb);
            n_checks++;
            if (st !== ST_H || sb !== SB_HALT) begin
                n_errors++;
                $display("FAIL halt_hold cycle %0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                         c + 1, st, sb, ST_H, SB_HALT);
            end
        end
        n_checks++;
        if (instret !== 32'd8) begin
            n_errors++;
            $display("FAIL halt_instret: instret=%0d, expected 8", instret);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (strobes() !== SB_NONE || state_dbg !== ST_F) begin
            n_errors++;
            $display("FAIL halt_reset_during: strobes=%b state=%0d, expected %b and %0d",
                     strobes(), state_dbg, SB_NONE, ST_F);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (state_dbg !== ST_F || halted !== 1'b0 || instret !== 32'd0) begin
            n_errors++;
            $display("FAIL halt_reset_after: state=%0d halted=%b instret=%0d, expected %0d, 0, 0",
                     state_dbg, halted, instret, ST_F);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [2:0]  st;
        logic [10:0] sb;
        row_t rows [5] = '{
            '{I_LOAD, 1'b1, 1'b0, ST_F, SB_F_RDY},
            '{I_LOAD, 1'b0, 1'b0, ST_D, SB_DEC},
            '{I_LOAD, 1'b0, 1'b0, ST_E, SB_DEC},
            '{I_LOAD, 1'b0, 1'b0, ST_M, SB_MEM_RD},
            '{I_LOAD, 1'b0, 1'b0, ST_M, SB_MEM_RD}
        };
        for (int c = 0; c < 5; c++) begin
            set_instr(rows[c].ins);
            cycle(rows[c].im, rows[c].dm, st, sb);
            n_checks++;
            if (st !== rows[c].st || sb !== rows[c].sb) begin
                n_errors++;
                $display("FAIL reset_mid_mem cycle %0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                         c + 1, st, sb, rows[c].st, rows[c].sb);
            end
        end
        // Ready arrives together with reset: the access must not complete.
        reset = 1'b1;
        mem_if.dmem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (strobes() !== SB_NONE) begin
            n_errors++;
            $display("FAIL reset_mid_mem_during: strobes=%b, expected %b", strobes(), SB_NONE);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1'b0, 1'b1, st, sb);
        n_checks++;
        if (st !== ST_F || sb !== SB_F_NORDY || instret !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_mid_mem_after: state=%0d strobes=%b instret=%0d, expected %0d, %b, 0",
                     st, sb, instret, ST_F, SB_F_NORDY);
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_if.imem_ready = 1'b0;
        mem_if.dmem_ready = 1'b0;
        set_instr(10'b0);
        test_reset();
        test_add();
        test_load_wait();
        test_back_to_back();
        test_illegal();
        test_fetch_timeout();
        test_data_timeout();
        test_halt();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
